// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, IR handshake to decode,
// and the redirect/halt controls from execute.
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_rdata;
    logic                  imem_rvalid;
    logic [31:0]           ir;
    logic [ADDR_WIDTH-1:0] ir_pc;
    logic                  ir_valid;
    logic                  ir_ready;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  halt;
    logic                  halted;

    modport master (
        output imem_req, imem_addr, ir, ir_pc, ir_valid, halted,
        input  imem_rdata, imem_rvalid, ir_ready,
        input  redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_pc, ir_valid, halted,
        output imem_rdata, imem_rvalid, ir_ready,
        output redirect_valid, redirect_pc, halt
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding word read, IR valid/ready
// handshake, PC redirect with in-flight kill, and halt.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        HALTED
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_ir_pc;
    logic [31:0]           r_ir;
    logic                  r_ir_valid;
    logic                  r_kill;

    logic                  w_xfer;
    state_t                w_resume;

    assign w_xfer   = r_ir_valid & bus.ir_ready & ~bus.redirect_valid;
    assign w_resume = bus.halt ? HALTED : ISSUE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.redirect_valid) begin
                        r_pc    <= bus.redirect_pc;
                        r_state <= ISSUE;
                    end else begin
                        r_state <= w_resume;
                    end
                end
                ISSUE: begin
                    // request is already on the bus; its data must be dropped
                    if (bus.redirect_valid) begin
                        r_pc   <= bus.redirect_pc;
                        r_kill <= 1'b1;
                    end
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus.redirect_valid) begin
                        r_pc <= bus.redirect_pc;
                        if (bus.imem_rvalid) begin
                            r_kill  <= 1'b0;
                            r_state <= ISSUE;
                        end else begin
                            r_kill  <= 1'b1;
                        end
                    end else if (bus.imem_rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= w_resume;
                        end else begin
                            r_ir       <= bus.imem_rdata;
                            r_ir_pc    <= r_pc;
                            r_pc       <= r_pc + 1'b1;
                            r_ir_valid <= 1'b1;
                            r_state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        r_pc       <= bus.redirect_pc;
                        r_ir_valid <= 1'b0;
                        r_state    <= ISSUE;
                    end else if (w_xfer) begin
                        r_ir_valid <= 1'b0;
                        r_state    <= w_resume;
                    end
                end
                HALTED: begin
                    if (bus.redirect_valid) begin
                        r_pc <= bus.redirect_pc;
                    end
                    if (!bus.halt) begin
                        r_state <= ISSUE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req  = (r_state == ISSUE);
    assign bus.imem_addr = (r_state == ISSUE) ? r_pc : '0;
    assign bus.ir        = r_ir;
    assign bus.ir_pc     = r_ir_pc;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.halted    = (r_state == HALTED);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table for the sequential flow, then
// directed redirect, halt, reset and narrow-PC sequences.
module tb_instr_fetch_unit;
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst4_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_WIDTH(32)) bus ();
    instr_fetch_unit_if #(.ADDR_WIDTH(4))  b4 ();

    instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    instr_fetch_unit #(.ADDR_WIDTH(4), .RESET_PC(4'hF)) dut4 (
        .clk  (clk),
        .rst_n(rst4_n),
        .bus  (b4)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h12345678;
        if (a == 32'd1) return 32'h0000ABCD;
        return 32'hA5000000 | {8'h00, a[23:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // memory model: response comes lat cycles after the request cycle
    int          lat        = 2;
    int          m_cnt      = 0;
    logic [31:0] m_addr     = '0;
    logic        m_rvalid   = 1'b0;
    logic [31:0] m_rdata    = '0;
    logic        mem_en     = 1'b1;
    logic        inj_rvalid = 1'b0;
    logic [31:0] inj_rdata  = '0;

    always @(negedge clk) begin
        m_rvalid = 1'b0;
        if (!mem_en) begin
            m_cnt = 0;
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_rvalid = 1'b1;
                    m_rdata  = mem_word(m_addr);
                end
            end
            if (bus.imem_req === 1'b1) begin
                m_cnt  = lat;
                m_addr = bus.imem_addr;
            end
        end
    end

    assign bus.imem_rvalid = mem_en ? m_rvalid : inj_rvalid;
    assign bus.imem_rdata  = mem_en ? m_rdata : inj_rdata;

    // narrow instance: fixed one-cycle memory, data = address
    logic       p4_req  = 1'b0;
    logic [3:0] p4_addr = '0;
    always @(negedge clk) begin
        b4.imem_rvalid = p4_req;
        b4.imem_rdata  = {28'h0, p4_addr};
        p4_req         = (b4.imem_req === 1'b1);
        p4_addr        = b4.imem_addr;
    end

    typedef struct {
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ir;
        logic [31:0] pc;
    } vec_t;

    vec_t vt [19];

    task automatic setv(input int i, input logic rd, input logic rq,
                        input logic [31:0] ad, input logic v,
                        input logic [31:0] ir, input logic [31:0] pc);
        vt[i] = '{rd, rq, ad, v, ir, pc};
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr,
                            output logic saw_valid);
        int n;
        n = 0;
        saw_valid = 1'b0;
        @(negedge clk);
        while (!bus.imem_req && n < 40) begin
            if (bus.ir_valid) saw_valid = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({name, ".req"}, {31'b0, bus.imem_req}, 32'd1);
        chk({name, ".addr"}, bus.imem_addr, exp_addr);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc,
                              input logic [31:0] exp_ir);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.ir_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({name, ".vld"}, {31'b0, bus.ir_valid}, 32'd1);
        chk({name, ".pc"}, bus.ir_pc, exp_pc);
        chk({name, ".ir"}, bus.ir, exp_ir);
    endtask

    logic       sv;
    int         bad;
    int         nreq;
    logic [3:0] a4 [2];
    logic       got4;
    logic [3:0] p4;
    logic [31:0] d4;

    initial begin
        bus.ir_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        b4.ir_ready        = 1'b1;
        b4.redirect_valid  = 1'b0;
        b4.redirect_pc     = '0;
        b4.halt            = 1'b0;

        setv(1,  1, 1, 0, 0, 0, 0);
        setv(2,  1, 0, 0, 0, 0, 0);
        setv(3,  1, 0, 0, 0, 0, 0);
        setv(4,  1, 0, 0, 1, 32'h12345678, 0);
        setv(5,  1, 1, 1, 0, 0, 0);
        setv(6,  1, 0, 0, 0, 0, 0);
        setv(7,  1, 0, 0, 0, 0, 0);
        for (int i = 8; i <= 12; i++)
            setv(i, 0, 0, 0, 1, 32'h0000ABCD, 1);
        setv(13, 1, 0, 0, 1, 32'h0000ABCD, 1);
        setv(14, 1, 1, 2, 0, 0, 0);
        setv(15, 1, 0, 0, 0, 0, 0);
        setv(16, 1, 0, 0, 0, 0, 0);
        setv(17, 1, 0, 0, 1, 32'hA5000002, 2);
        setv(18, 1, 1, 3, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst.req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst.addr", bus.imem_addr, 32'd0);
        chk("rst.vld", {31'b0, bus.ir_valid}, 32'd0);
        chk("rst.ir", bus.ir, 32'd0);
        chk("rst.pc", bus.ir_pc, 32'd0);
        chk("rst.halted", {31'b0, bus.halted}, 32'd0);
        rst_n = 1'b1;

        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d.req", i), {31'b0, bus.imem_req},
                {31'b0, vt[i].req});
            if (vt[i].req)
                chk($sformatf("vec%0d.addr", i), bus.imem_addr, vt[i].addr);
            chk($sformatf("vec%0d.vld", i), {31'b0, bus.ir_valid},
                {31'b0, vt[i].vld});
            if (vt[i].vld) begin
                chk($sformatf("vec%0d.ir", i), bus.ir, vt[i].ir);
                chk($sformatf("vec%0d.pc", i), bus.ir_pc, vt[i].pc);
            end
            bus.ir_ready = vt[i].ready;
        end

        wait_valid("seq3", 32'd3, mem_word(3));
        lat = 3;

        // redirect during WAIT
        wait_req("rdw.pre", 32'd4, sv);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        wait_req("rdw", 32'h40, sv);
        chk("rdw.drop", {31'b0, sv}, 32'd0);
        wait_valid("rdw", 32'h40, mem_word(32'h40));

        // redirect in the ISSUE cycle
        wait_req("rdi.pre", 32'h41, sv);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        wait_req("rdi", 32'h80, sv);
        chk("rdi.drop", {31'b0, sv}, 32'd0);
        bus.ir_ready = 1'b0;
        wait_valid("rdi", 32'h80, mem_word(32'h80));

        // redirect and ready in the same HOLD cycle drops the instruction
        bus.ir_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h20;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("rdh.vld", {31'b0, bus.ir_valid}, 32'd0);
        chk("rdh.req", {31'b0, bus.imem_req}, 32'd1);
        chk("rdh.addr", bus.imem_addr, 32'h20);
        wait_valid("rdh", 32'h20, mem_word(32'h20));

        // halt raised mid-fetch; sequential resume
        wait_req("hlt.pre", 32'h21, sv);
        @(negedge clk);
        bus.halt = 1'b1;
        wait_valid("hlt", 32'h21, mem_word(32'h21));
        @(negedge clk);
        chk("hlt.halted", {31'b0, bus.halted}, 32'd1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.imem_req || !bus.halted) bad++;
        end
        chk("hlt.quiet", bad, 0);
        bus.halt = 1'b0;
        @(negedge clk);
        chk("hlt.res.halted", {31'b0, bus.halted}, 32'd0);
        chk("hlt.res.req", {31'b0, bus.imem_req}, 32'd1);
        chk("hlt.res.addr", bus.imem_addr, 32'h22);

        // halt again, redirect while halted
        bus.halt = 1'b1;
        wait_valid("hlt2", 32'h22, mem_word(32'h22));
        @(negedge clk);
        chk("hlt2.halted", {31'b0, bus.halted}, 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h60;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("hlt2.stay", {31'b0, bus.halted}, 32'd1);
        chk("hlt2.noreq", {31'b0, bus.imem_req}, 32'd0);
        bus.halt = 1'b0;
        @(negedge clk);
        chk("hlt2.res.req", {31'b0, bus.imem_req}, 32'd1);
        chk("hlt2.res.addr", bus.imem_addr, 32'h60);
        wait_valid("hlt2.res", 32'h60, mem_word(32'h60));

        // asynchronous reset during WAIT, stray responses afterwards
        wait_req("rst2.pre", 32'h61, sv);
        @(negedge clk);
        mem_en     = 1'b0;
        inj_rvalid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("rst2.ir", bus.ir, 32'd0);
        chk("rst2.pc", bus.ir_pc, 32'd0);
        chk("rst2.vld", {31'b0, bus.ir_valid}, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        inj_rvalid = 1'b1;
        inj_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        chk("rst2.req", {31'b0, bus.imem_req}, 32'd1);
        chk("rst2.addr", bus.imem_addr, 32'd0);
        @(negedge clk);
        chk("rst2.stray", {31'b0, bus.ir_valid}, 32'd0);
        inj_rdata = mem_word(0);
        @(negedge clk);
        inj_rvalid = 1'b0;
        chk("rst2.vld1", {31'b0, bus.ir_valid}, 32'd1);
        chk("rst2.pc1", bus.ir_pc, 32'd0);
        chk("rst2.ir1", bus.ir, 32'h12345678);
        mem_en = 1'b1;
        wait_valid("rst2.next", 32'd1, mem_word(1));

        // 4-bit PC wraps from 15 to 0
        @(negedge clk);
        rst4_n = 1'b1;
        nreq   = 0;
        got4   = 1'b0;
        p4     = '0;
        d4     = '0;
        a4[0]  = '0;
        a4[1]  = '0;
        for (int k = 0; k < 20 && nreq < 2; k++) begin
            @(negedge clk);
            if (b4.imem_req) begin
                a4[nreq] = b4.imem_addr;
                nreq++;
            end
            if (b4.ir_valid && !got4) begin
                got4 = 1'b1;
                p4   = b4.ir_pc;
                d4   = b4.ir;
            end
        end
        chk("w4.nreq", nreq, 2);
        chk("w4.addr0", {28'h0, a4[0]}, 32'hF);
        chk("w4.addr1", {28'h0, a4[1]}, 32'h0);
        chk("w4.pc", {28'h0, p4}, 32'hF);
        chk("w4.ir", d4, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
